// File: rtl/bnn_layer_sequencer_pkg.sv
// Shared definitions for the BNN layer sequencer: the state bus encoding
// (also decoded by loader/layer_one/layer_two/layer_three) and stall codes.
package bnn_layer_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_LOAD    = 3'b001,
    S_LAYER_1 = 3'b010,
    S_LAYER_2 = 3'b011,
    S_LAYER_3 = 3'b100,
    S_OUTPUT  = 3'b101,
    S_CLEAR   = 3'b110,
    S_ERROR   = 3'b111
  } state_e;

  // Stage that stalled, reported on err_code.
  localparam logic [1:0] ERR_LOAD = 2'd0;
  localparam logic [1:0] ERR_L1   = 2'd1;
  localparam logic [1:0] ERR_L2   = 2'd2;
  localparam logic [1:0] ERR_L3   = 2'd3;

  // True for the four compute stages that are watchdogged and counted.
  function automatic logic is_stage(input state_e s);
    return (s == S_LOAD) || (s == S_LAYER_1) || (s == S_LAYER_2) || (s == S_LAYER_3);
  endfunction

endpackage

// File: rtl/bnn_layer_sequencer_timer.sv
// Per-stage watchdog timer: cleared on any state change, counts while the
// sequencer sits in a compute stage, flags when it reaches TIMEOUT.
module bnn_layer_sequencer_timer #(
  parameter int TIMEOUT = 4095,
  parameter int WDOG_W  = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [WDOG_W-1:0] cnt_q;

  // Clear has priority over counting; the sequencer leaves the stage on
  // expiry, so the counter never has to go past TIMEOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = (cnt_q == WDOG_W'(TIMEOUT));

endmodule

// File: rtl/bnn_layer_sequencer.sv
// Top-level scheduler for the BNN pipeline. Drives the shared state bus,
// sequences CLEAR -> LOAD -> LAYER_1 -> LAYER_2 -> LAYER_3 -> OUTPUT,
// watchdogs each stage and counts inference cycles.
//
// Result handshake: result_valid is high for every cycle the FSM is in
// S_OUTPUT and cycle_count is held stable meanwhile; the result is consumed
// on the rising clock edge where result_valid && result_ready, after which
// the FSM returns to S_IDLE. result_ready may be held low indefinitely.
module bnn_layer_sequencer
  import bnn_layer_sequencer_pkg::*;
#(
  parameter int CLEAR_CYCLES = 2,
  parameter int TIMEOUT      = 4095,
  parameter int WDOG_W       = 12,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             load_done,
  input  logic             l1_done,
  input  logic             l2_done,
  input  logic             l3_done,
  input  logic             result_ready,
  output logic [2:0]       state,
  output logic             layers_rst_n,
  output logic             busy,
  output logic             result_valid,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);

  state_e            state_q, state_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              layers_rst_n_q;
  logic [CLR_W-1:0]  clr_cnt_q;
  logic [CNT_W-1:0]  cycle_count_q;
  logic              in_stage;
  logic              timer_expired;

  assign in_stage = is_stage(state_q);

  bnn_layer_sequencer_timer #(
    .TIMEOUT (TIMEOUT),
    .WDOG_W  (WDOG_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_d != state_q),
    .en_i      (in_stage),
    .expired_o (timer_expired)
  );

  // Next-state logic; priority is abort, then the stage's done, then timeout.
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_ERROR: begin
        if (start) begin
          state_d    = S_CLEAR;
          err_code_d = ERR_LOAD;
        end
      end
      S_CLEAR: begin
        if (clr_cnt_q == CLR_LAST) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (load_done) begin
          state_d = S_LAYER_1;
        end else if (timer_expired) begin
          state_d    = S_ERROR;
          err_code_d = ERR_LOAD;
        end
      end
      S_LAYER_1: begin
        if (l1_done) begin
          state_d = S_LAYER_2;
        end else if (timer_expired) begin
          state_d    = S_ERROR;
          err_code_d = ERR_L1;
        end
      end
      S_LAYER_2: begin
        if (l2_done) begin
          state_d = S_LAYER_3;
        end else if (timer_expired) begin
          state_d    = S_ERROR;
          err_code_d = ERR_L2;
        end
      end
      S_LAYER_3: begin
        if (l3_done) begin
          state_d = S_OUTPUT;
        end else if (timer_expired) begin
          state_d    = S_ERROR;
          err_code_d = ERR_L3;
        end
      end
      S_OUTPUT: begin
        if (result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d    = S_IDLE;
      err_code_d = ERR_LOAD;
    end
  end

  // State, stall code and the layers' reset, which is low exactly while in CLEAR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      err_code_q     <= ERR_LOAD;
      layers_rst_n_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      err_code_q     <= err_code_d;
      layers_rst_n_q <= (state_d != S_CLEAR);
    end
  end

  // Counts cycles spent in CLEAR so the layers see exactly CLEAR_CYCLES of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt_q <= '0;
    end else if ((state_q == S_CLEAR) && (state_d == S_CLEAR)) begin
      clr_cnt_q <= clr_cnt_q + 1'b1;
    end else begin
      clr_cnt_q <= '0;
    end
  end

  // Inference cycle counter: zeroed in CLEAR, saturating count in the stages,
  // held everywhere else (so an abort keeps the partial count).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count_q <= '0;
    end else if (state_q == S_CLEAR) begin
      cycle_count_q <= '0;
    end else if (in_stage && (cycle_count_q != {CNT_W{1'b1}})) begin
      cycle_count_q <= cycle_count_q + 1'b1;
    end
  end

  assign state        = state_q;
  assign layers_rst_n = layers_rst_n_q;
  assign busy         = (state_q == S_CLEAR) || in_stage;
  assign result_valid = (state_q == S_OUTPUT);
  assign error        = (state_q == S_ERROR);
  assign err_code     = err_code_q;
  assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Bench for bnn_layer_sequencer: directed scenarios plus randomized images.
// Expected results are built from the stage durations the driver chooses.
module tb_bnn_layer_sequencer;

  localparam int CLEAR_CYCLES = 2;
  localparam int TIMEOUT      = 4095;
  localparam int WDOG_W       = 12;
  localparam int CNT_W        = 16;

  localparam logic [2:0] ST_IDLE = 3'b000, ST_LOAD = 3'b001, ST_L1 = 3'b010,
                         ST_L2 = 3'b011, ST_L3 = 3'b100, ST_OUT = 3'b101,
                         ST_CLEAR = 3'b110, ST_ERR = 3'b111;

  logic             clk, rst;
  logic             start, abort, load_done, l1_done, l2_done, l3_done, result_ready;
  logic [2:0]       state;
  logic             layers_rst_n, busy, result_valid, error;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] cycle_count;

  logic [CNT_W-1:0] exp_q[$];
  logic [1:0]       err_exp_q[$];
  int               n_checks = 0;
  int               n_pass   = 0;
  logic             err_prev = 1'b0;

  bnn_layer_sequencer #(
    .CLEAR_CYCLES (CLEAR_CYCLES),
    .TIMEOUT      (TIMEOUT),
    .WDOG_W       (WDOG_W),
    .CNT_W        (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .load_done    (load_done),
    .l1_done      (l1_done),
    .l2_done      (l2_done),
    .l3_done      (l3_done),
    .result_ready (result_ready),
    .state        (state),
    .layers_rst_n (layers_rst_n),
    .busy         (busy),
    .result_valid (result_valid),
    .error        (error),
    .err_code     (err_code),
    .cycle_count  (cycle_count)
  );

  // Clock and overall time limit
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_500_000;
    $display("FAIL time_limit: run did not finish, got %0d/%0d", n_pass, n_checks);
    $fatal(1, "time limit");
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_dones();
    load_done = 1'b0; l1_done = 1'b0; l2_done = 1'b0; l3_done = 1'b0;
  endtask

  task automatic set_done(input int k, input logic v);
    case (k)
      0: load_done = v;
      1: l1_done   = v;
      2: l2_done   = v;
      default: l3_done = v;
    endcase
  endtask

  // Randomly raise the done lines of every stage except the current one.
  task automatic set_stale(input int cur);
    for (int j = 0; j < 4; j++)
      if (j != cur) set_done(j, 1'($urandom_range(0, 1)));
      else set_done(j, 1'b0);
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, output bit ok);
    int n;
    n = 0;
    while (state !== s && n < max) begin
      tick();
      n++;
    end
    ok = (state === s);
  endtask

  // Walks an already-started image through its stages. tmo_stage >= 0 lets
  // that stage starve; otherwise the result is held for ready_delay cycles.
  task automatic drive_stages(input int tmo_stage, input int ready_delay);
    int d, total, n;
    bit ok;
    total = 0;
    for (int k = 0; k < 4; k++) begin
      wait_state(3'(k + 1), CLEAR_CYCLES + 4, ok);
      check($sformatf("enter_stage%0d", k), {31'd0, ok}, 32'd1);
      if (!ok) begin
        clear_dones();
        return;
      end
      if (k == tmo_stage) begin
        err_exp_q.push_back(2'(k));
        set_stale(k);
        n = 0;
        while (state === 3'(k + 1) && n < TIMEOUT + 10) begin
          tick();
          n++;
        end
        clear_dones();
        check("timeout_len", n, TIMEOUT + 1);
        check("timeout_state", state, ST_ERR);
        return;
      end
      d = $urandom_range(0, 5);
      repeat (d) begin
        set_stale(k);
        tick();
      end
      clear_dones();
      set_done(k, 1'b1);
      total += d + 1;
      if (k == 3) exp_q.push_back(CNT_W'(total));
      tick();
      clear_dones();
    end
    check("reach_output", state, ST_OUT);
    repeat (ready_delay) begin
      check("hold_output", state, ST_OUT);
      check("hold_valid", result_valid, 1);
      tick();
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("back_idle", state, ST_IDLE);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Scoreboard monitor: compares results and stall codes as the DUT shows them.
  always begin
    @(negedge clk);
    if (!rst) begin
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", result_valid, 0);
        end else begin
          check("cycle_count", cycle_count, exp_q[0]);
          if (result_ready) void'(exp_q.pop_front());
        end
      end
      if (error && !err_prev) begin
        if (err_exp_q.size() == 0) check("unexpected_error", error, 0);
        else check("err_code", err_code, err_exp_q.pop_front());
      end
      err_prev = error;
    end else begin
      err_prev = 1'b0;
    end
  end

  // Stimulus
  initial begin
    bit ok;
    rst = 1'b1; start = 1'b0; abort = 1'b0; result_ready = 1'b0;
    clear_dones();
    tick(); tick();

    // Reset values
    check("rst_state", state, ST_IDLE);
    check("rst_lrn", layers_rst_n, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_error", error, 0);
    check("rst_err_code", err_code, 0);
    check("rst_count", cycle_count, 0);
    rst = 1'b0;
    tick();
    check("lrn_after_rst", layers_rst_n, 1);

    // 1: every done already high on stage entry
    exp_q.push_back(CNT_W'(4));
    load_done = 1'b1; l1_done = 1'b1; l2_done = 1'b1; l3_done = 1'b1;
    pulse_start();
    check("n_clear0", state, ST_CLEAR);
    check("n_lrn0", layers_rst_n, 0);
    check("n_busy0", busy, 1);
    tick();
    check("n_clear1", state, ST_CLEAR);
    check("n_lrn1", layers_rst_n, 0);
    tick();
    check("n_load", state, ST_LOAD);
    check("n_lrn2", layers_rst_n, 1);
    tick(); check("n_l1", state, ST_L1);
    tick(); check("n_l2", state, ST_L2);
    tick(); check("n_l3", state, ST_L3);
    tick(); check("n_out", state, ST_OUT);
    check("n_valid", result_valid, 1);
    check("n_busy_out", busy, 0);
    check("n_count", cycle_count, 4);
    clear_dones();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("n_idle", state, ST_IDLE);

    // 2: layer two never finishes
    pulse_start();
    drive_stages(2, 0);
    check("t_error", error, 1);
    check("t_err_code", err_code, 2);
    check("t_busy", busy, 0);
    pulse_start();
    check("t_restart", state, ST_CLEAR);
    check("t_error_clr", error, 0);
    check("t_code_clr", err_code, 0);
    drive_stages(-1, 0);

    // 3: long backpressure on the result
    pulse_start();
    drive_stages(-1, 20);

    // 4: start pulses and a stale l3_done while running
    pulse_start();
    wait_state(ST_LOAD, CLEAR_CYCLES + 4, ok);
    check("s_load", {31'd0, ok}, 1);
    load_done = 1'b1; tick(); load_done = 1'b0;
    check("s_l1", state, ST_L1);
    start = 1'b1; l3_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s_l1_hold", state, ST_L1);
    end
    start = 1'b0; l3_done = 1'b0; l1_done = 1'b1;
    tick();
    l1_done = 1'b0;
    check("s_l2", state, ST_L2);
    start = 1'b1;
    tick(); check("s_l2_hold", state, ST_L2);
    tick(); check("s_l2_hold", state, ST_L2);
    start = 1'b0; l2_done = 1'b1;
    tick();
    l2_done = 1'b0;
    check("s_l3", state, ST_L3);
    exp_q.push_back(CNT_W'(9));
    l3_done = 1'b1;
    tick();
    l3_done = 1'b0;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("s_idle", state, ST_IDLE);

    // 5: asynchronous reset in the middle of layer two
    pulse_start();
    wait_state(ST_LOAD, CLEAR_CYCLES + 4, ok);
    load_done = 1'b1; tick(); load_done = 1'b0;
    l1_done = 1'b1; tick(); l1_done = 1'b0;
    check("r_l2", state, ST_L2);
    #4 rst = 1'b1;
    #1;
    check("r_state", state, ST_IDLE);
    check("r_lrn", layers_rst_n, 0);
    check("r_busy", busy, 0);
    tick();
    rst = 1'b0;
    tick();
    check("r_lrn_back", layers_rst_n, 1);
    check("r_count", cycle_count, 0);

    // 6: abort beats l1_done; abort beats start
    pulse_start();
    wait_state(ST_LOAD, CLEAR_CYCLES + 4, ok);
    load_done = 1'b1; tick(); load_done = 1'b0;
    check("a_l1", state, ST_L1);
    abort = 1'b1; l1_done = 1'b1;
    tick();
    abort = 1'b0; l1_done = 1'b0;
    check("a_state", state, ST_IDLE);
    check("a_busy", busy, 0);
    check("a_error", error, 0);
    check("a_lrn", layers_rst_n, 1);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("a_start_abort", state, ST_IDLE);

    // Randomized images
    for (int i = 0; i < 12; i++) begin
      pulse_start();
      drive_stages(-1, $urandom_range(0, 3));
    end

    // Random stage stalls, then abort out of ERROR
    pulse_start();
    drive_stages($urandom_range(0, 3), 0);
    check("e_error", error, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("e_abort_state", state, ST_IDLE);
    check("e_abort_error", error, 0);
    check("e_abort_code", err_code, 0);

    tick(); tick();
    check("results_drained", exp_q.size(), 0);
    check("errors_drained", err_exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
